// File: rtl/coprocessor0_pkg.sv
// Shared types and constants for coprocessor 0: writeback bus layout,
// register numbers, Status/Cause bit positions and exception codes.
package coprocessor0_params;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [2:0] SEL_0       = 3'd0;

  localparam int STATUS_BEV   = 22;
  localparam int STATUS_IM_HI = 15;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IE    = 0;

  localparam int CAUSE_BD       = 31;
  localparam int CAUSE_TI       = 30;
  localparam int CAUSE_IP_HI    = 15;
  localparam int CAUSE_IP_HW_LO = 10;
  localparam int CAUSE_IP_SW_HI = 9;
  localparam int CAUSE_IP_LO    = 8;
  localparam int CAUSE_EXC_HI   = 6;
  localparam int CAUSE_EXC_LO   = 2;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_MOD  = 5'h01,
    EXC_TLBL = 5'h02,
    EXC_TLBS = 5'h03,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_IBE  = 5'h06,
    EXC_DBE  = 5'h07,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_CPU  = 5'h0b,
    EXC_OV   = 5'h0c,
    EXC_TR   = 5'h0d
  } ExceptionCode;

  typedef struct packed {
    logic [4:0]  address_register;
    logic [2:0]  address_select;
    logic        write_enabled;
    logic [31:0] write_data;
    logic        exception_valid;
    logic [31:0] exception_address;
    logic        eret_flush;
    logic        in_delay_slot;
    logic [4:0]  exception_code;
  } WBToCP0Data;

endpackage

// File: rtl/coprocessor0_timer.sv
// Count/Compare timer: Count advances once every two clocks, TI latches
// when Count matches Compare and is released only by a Compare write.
module cp0_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  logic        r_tick;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;

  // Half-rate tick and Count; a software write wins over the increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tick  <= 1'b0;
      r_count <= 32'd0;
    end else begin
      r_tick <= ~r_tick;
      if (i_count_we)
        r_count <= i_wdata;
      else if (r_tick)
        r_count <= r_count + 32'd1;
    end
  end

  // Compare register and sticky timer-interrupt flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_compare <= 32'd0;
      r_ti      <= 1'b0;
    end else if (i_compare_we) begin
      r_compare <= i_wdata;
      r_ti      <= 1'b0;
    end else if (r_count == r_compare) begin
      r_ti <= 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/coprocessor0.sv
// MIPS-style coprocessor 0: Status, Cause, EPC plus the Count/Compare
// timer, with exception entry, eret and mtc0 handling from writeback.
module coprocessor0
  import coprocessor0_params::*;
(
  input  logic        clock,
  input  logic        reset,
  input  WBToCP0Data  wb_to_cp0_data_bus,
  input  logic [5:0]  hardware_interrupt,
  output logic [31:0] cp0_read_data,
  output logic [31:0] exception_program_count,
  output logic        interrupt_pending
);

  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip_hw;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  logic        w_ti;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_wr;
  logic        w_sel0;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_epc_next;

  // A write only lands when neither exception nor eret claims the cycle.
  assign w_wr         = wb_to_cp0_data_bus.write_enabled & ~wb_to_cp0_data_bus.exception_valid
                        & ~wb_to_cp0_data_bus.eret_flush;
  assign w_sel0       = (wb_to_cp0_data_bus.address_select == SEL_0);
  assign w_wr_count   = w_wr & w_sel0 & (wb_to_cp0_data_bus.address_register == REG_COUNT);
  assign w_wr_compare = w_wr & w_sel0 & (wb_to_cp0_data_bus.address_register == REG_COMPARE);
  assign w_wr_status  = w_wr & w_sel0 & (wb_to_cp0_data_bus.address_register == REG_STATUS);
  assign w_wr_cause   = w_wr & w_sel0 & (wb_to_cp0_data_bus.address_register == REG_CAUSE);
  assign w_wr_epc     = w_wr & w_sel0 & (wb_to_cp0_data_bus.address_register == REG_EPC);

  assign w_epc_next = wb_to_cp0_data_bus.in_delay_slot
                      ? (wb_to_cp0_data_bus.exception_address - 32'd4)
                      : wb_to_cp0_data_bus.exception_address;

  cp0_timer u_timer (
    .clock        (clock),
    .reset        (reset),
    .i_count_we   (w_wr_count),
    .i_compare_we (w_wr_compare),
    .i_wdata      (wb_to_cp0_data_bus.write_data),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );

  // Status/Cause/EPC state: exception > eret > mtc0, IP lines sampled each cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_im       <= 8'd0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip_hw    <= 6'd0;
      r_ip_sw    <= 2'd0;
      r_exc_code <= 5'd0;
      r_epc      <= 32'd0;
    end else begin
      r_ip_hw <= {hardware_interrupt[5] | w_ti, hardware_interrupt[4:0]};
      if (wb_to_cp0_data_bus.exception_valid) begin
        r_exl      <= 1'b1;
        r_exc_code <= wb_to_cp0_data_bus.exception_code;
        // A nested exception keeps the original return point.
        if (!r_exl) begin
          r_epc <= w_epc_next;
          r_bd  <= wb_to_cp0_data_bus.in_delay_slot;
        end
      end else if (wb_to_cp0_data_bus.eret_flush) begin
        r_exl <= 1'b0;
      end else begin
        if (w_wr_status) begin
          r_im  <= wb_to_cp0_data_bus.write_data[STATUS_IM_HI:STATUS_IM_LO];
          r_exl <= wb_to_cp0_data_bus.write_data[STATUS_EXL];
          r_ie  <= wb_to_cp0_data_bus.write_data[STATUS_IE];
        end
        if (w_wr_cause)
          r_ip_sw <= wb_to_cp0_data_bus.write_data[CAUSE_IP_SW_HI:CAUSE_IP_LO];
        if (w_wr_epc)
          r_epc <= wb_to_cp0_data_bus.write_data;
      end
    end
  end

  // Assemble architectural Status and Cause views; unused bits read 0.
  always_comb begin
    w_status                            = 32'd0;
    w_status[STATUS_BEV]                = 1'b1;
    w_status[STATUS_IM_HI:STATUS_IM_LO] = r_im;
    w_status[STATUS_EXL]                = r_exl;
    w_status[STATUS_IE]                 = r_ie;
    w_cause                                = 32'd0;
    w_cause[CAUSE_BD]                      = r_bd;
    w_cause[CAUSE_TI]                      = w_ti;
    w_cause[CAUSE_IP_HI:CAUSE_IP_HW_LO]    = r_ip_hw;
    w_cause[CAUSE_IP_SW_HI:CAUSE_IP_LO]    = r_ip_sw;
    w_cause[CAUSE_EXC_HI:CAUSE_EXC_LO]     = r_exc_code;
  end

  // Combinational mfc0 read port.
  always_comb begin
    cp0_read_data = 32'd0;
    if (w_sel0) begin
      case (wb_to_cp0_data_bus.address_register)
        REG_COUNT:   cp0_read_data = w_count;
        REG_COMPARE: cp0_read_data = w_compare;
        REG_STATUS:  cp0_read_data = w_status;
        REG_CAUSE:   cp0_read_data = w_cause;
        REG_EPC:     cp0_read_data = r_epc;
        default:     cp0_read_data = 32'd0;
      endcase
    end
  end

  assign exception_program_count = r_epc;
  assign interrupt_pending = (|({r_ip_hw, r_ip_sw} & r_im)) & r_ie & ~r_exl;

endmodule

// File: tb/tb_coprocessor0.sv
// Directed bench for coprocessor0: reset, timer, exceptions, priority,
// register write masks and interrupt gating.
module tb_coprocessor0;
  import coprocessor0_params::*;

  logic        clock;
  logic        reset;
  WBToCP0Data  bus;
  logic [5:0]  hardware_interrupt;
  logic [31:0] cp0_read_data;
  logic [31:0] exception_program_count;
  logic        interrupt_pending;

  int n_checks = 0;
  int n_pass   = 0;

  coprocessor0 dut (
    .clock                   (clock),
    .reset                   (reset),
    .wb_to_cp0_data_bus      (bus),
    .hardware_interrupt      (hardware_interrupt),
    .cp0_read_data           (cp0_read_data),
    .exception_program_count (exception_program_count),
    .interrupt_pending       (interrupt_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [4:0] r, input logic [2:0] s, output logic [31:0] v);
    bus.address_register = r;
    bus.address_select   = s;
    #1;
    v = cp0_read_data;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [2:0] s, input logic [31:0] d);
    bus.address_register = r;
    bus.address_select   = s;
    bus.write_data       = d;
    bus.write_enabled    = 1'b1;
    step();
    bus.write_enabled    = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] addr, input logic ds);
    bus.exception_code    = code;
    bus.exception_address = addr;
    bus.in_delay_slot     = ds;
    bus.exception_valid   = 1'b1;
    step();
    bus.exception_valid   = 1'b0;
  endtask

  task automatic eret();
    bus.eret_flush = 1'b1;
    step();
    bus.eret_flush = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    bus = '0;
    hardware_interrupt = 6'd0;
    reset = 1'b1;
    step();
    step();
    // reset held while exception, eret and a Status write all request the same cycle
    bus.exception_valid   = 1'b1;
    bus.exception_address = 32'h1234_5678;
    bus.exception_code    = 5'h08;
    bus.eret_flush        = 1'b1;
    bus.write_enabled     = 1'b1;
    bus.address_register  = REG_STATUS;
    bus.write_data        = 32'h0000_ffff;
    step();
    rd(REG_STATUS, 3'd0, v);
    n_checks++; if (v !== 32'h0040_0000) $display("FAIL reset_status got=%h exp=%h", v, 32'h0040_0000); else n_pass++;
    rd(REG_CAUSE, 3'd0, v);
    n_checks++; if (v !== 32'h0) $display("FAIL reset_cause got=%h exp=0", v); else n_pass++;
    rd(REG_EPC, 3'd0, v);
    n_checks++; if (v !== 32'h0) $display("FAIL reset_epc got=%h exp=0", v); else n_pass++;
    rd(REG_COUNT, 3'd0, v);
    n_checks++; if (v !== 32'h0) $display("FAIL reset_count got=%h exp=0", v); else n_pass++;
    n_checks++; if (exception_program_count !== 32'h0) $display("FAIL reset_epc_out got=%h exp=0", exception_program_count); else n_pass++;
    n_checks++; if (interrupt_pending !== 1'b0) $display("FAIL reset_irq got=%b exp=0", interrupt_pending); else n_pass++;
    bus = '0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_timer();
    logic [31:0] v;
    int k;
    mtc0(REG_COMPARE, 3'd0, 32'd5);
    mtc0(REG_COUNT, 3'd0, 32'd0);
    rd(REG_COUNT, 3'd0, v);
    n_checks++; if (v !== 32'd0) $display("FAIL count_load got=%h exp=0", v); else n_pass++;
    for (k = 1; k <= 20; k++) begin
      step();
      rd(REG_COUNT, 3'd0, v);
      if (v == 32'd5) break;
    end
    n_checks++; if (!(k == 9 || k == 10)) $display("FAIL count_rate cycles=%0d exp=9or10", k); else n_pass++;
    rd(REG_CAUSE, 3'd0, v);
    n_checks++; if (v !== 32'h0) $display("FAIL ti_early cause=%h exp=0", v); else n_pass++;
    step();
    rd(REG_CAUSE, 3'd0, v);
    n_checks++; if (v !== 32'h4000_0000) $display("FAIL ti_set cause=%h exp=%h", v, 32'h4000_0000); else n_pass++;
    mtc0(REG_STATUS, 3'd0, 32'h0000_8001);
    rd(REG_CAUSE, 3'd0, v);
    n_checks++; if (v !== 32'h4000_8000) $display("FAIL ip7 cause=%h exp=%h", v, 32'h4000_8000); else n_pass++;
    n_checks++; if (interrupt_pending !== 1'b1) $display("FAIL timer_irq got=%b exp=1", interrupt_pending); else n_pass++;
    mtc0(REG_COMPARE, 3'd0, 32'h0000_1000);
    rd(REG_CAUSE, 3'd0, v);
    n_checks++; if (v !== 32'h0000_8000) $display("FAIL ti_clear cause=%h exp=%h", v, 32'h0000_8000); else n_pass++;
    step();
    rd(REG_CAUSE, 3'd0, v);
    n_checks++; if (v !== 32'h0) $display("FAIL ip7_clear cause=%h exp=0", v); else n_pass++;
    n_checks++; if (interrupt_pending !== 1'b0) $display("FAIL timer_irq_off got=%b exp=0", interrupt_pending); else n_pass++;
    rd(REG_COMPARE, 3'd0, v);
    n_checks++; if (v !== 32'h0000_1000) $display("FAIL compare_rd got=%h exp=%h", v, 32'h0000_1000); else n_pass++;
    mtc0(REG_STATUS, 3'd0, 32'h0);
    mtc0(REG_COUNT, 3'd0, 32'hffff_ffff);
    rd(REG_COUNT, 3'd0, v);
    n_checks++; if (v !== 32'hffff_ffff) $display("FAIL count_max got=%h exp=ffffffff", v); else n_pass++;
    for (k = 1; k <= 4; k++) begin
      step();
      rd(REG_COUNT, 3'd0, v);
      if (v == 32'd0) break;
    end
    n_checks++; if (!(k == 1 || k == 2)) $display("FAIL count_wrap cycles=%0d exp=1or2", k); else n_pass++;
  endtask

  task automatic test_exception();
    logic [31:0] v;
    exc(5'h08, 32'hbfc0_0100, 1'b1);
    rd(REG_EPC, 3'd0, v);
    n_checks++; if (v !== 32'hbfc0_00fc) $display("FAIL exc_epc got=%h exp=%h", v, 32'hbfc0_00fc); else n_pass++;
    n_checks++; if (exception_program_count !== 32'hbfc0_00fc) $display("FAIL exc_epc_out got=%h exp=%h", exception_program_count, 32'hbfc0_00fc); else n_pass++;
    rd(REG_STATUS, 3'd0, v);
    n_checks++; if (v !== 32'h0040_0002) $display("FAIL exc_exl got=%h exp=%h", v, 32'h0040_0002); else n_pass++;
    rd(REG_CAUSE, 3'd0, v);
    n_checks++; if (v !== 32'h8000_0020) $display("FAIL exc_cause got=%h exp=%h", v, 32'h8000_0020); else n_pass++;
  endtask

  task automatic test_nested();
    logic [31:0] v;
    exc(5'h0c, 32'h0000_0100, 1'b0);
    rd(REG_EPC, 3'd0, v);
    n_checks++; if (v !== 32'hbfc0_00fc) $display("FAIL nest_epc got=%h exp=%h", v, 32'hbfc0_00fc); else n_pass++;
    rd(REG_CAUSE, 3'd0, v);
    n_checks++; if (v !== 32'h8000_0030) $display("FAIL nest_cause got=%h exp=%h", v, 32'h8000_0030); else n_pass++;
    eret();
    rd(REG_STATUS, 3'd0, v);
    n_checks++; if (v !== 32'h0040_0000) $display("FAIL eret_exl got=%h exp=%h", v, 32'h0040_0000); else n_pass++;
    exc(5'h04, 32'h0000_0200, 1'b0);
    rd(REG_EPC, 3'd0, v);
    n_checks++; if (v !== 32'h0000_0200) $display("FAIL nods_epc got=%h exp=%h", v, 32'h0000_0200); else n_pass++;
    rd(REG_CAUSE, 3'd0, v);
    n_checks++; if (v !== 32'h0000_0010) $display("FAIL nods_cause got=%h exp=%h", v, 32'h0000_0010); else n_pass++;
    eret();
    exc(5'h08, 32'h0000_0000, 1'b1);
    rd(REG_EPC, 3'd0, v);
    n_checks++; if (v !== 32'hffff_fffc) $display("FAIL epc_wrap got=%h exp=%h", v, 32'hffff_fffc); else n_pass++;
    eret();
  endtask

  task automatic test_priority();
    logic [31:0] v;
    bus.exception_code    = 5'h00;
    bus.exception_address = 32'h0000_0040;
    bus.in_delay_slot     = 1'b0;
    bus.exception_valid   = 1'b1;
    bus.eret_flush        = 1'b1;
    bus.address_register  = REG_STATUS;
    bus.address_select    = 3'd0;
    bus.write_data        = 32'h0000_ff01;
    bus.write_enabled     = 1'b1;
    step();
    bus.exception_valid = 1'b0;
    bus.eret_flush      = 1'b0;
    bus.write_enabled   = 1'b0;
    rd(REG_STATUS, 3'd0, v);
    n_checks++; if (v !== 32'h0040_0002) $display("FAIL prio_status got=%h exp=%h", v, 32'h0040_0002); else n_pass++;
    rd(REG_EPC, 3'd0, v);
    n_checks++; if (v !== 32'h0000_0040) $display("FAIL prio_epc got=%h exp=%h", v, 32'h0000_0040); else n_pass++;
    rd(REG_CAUSE, 3'd0, v);
    n_checks++; if (v !== 32'h0) $display("FAIL prio_cause got=%h exp=0", v); else n_pass++;
    bus.eret_flush       = 1'b1;
    bus.address_register = REG_STATUS;
    bus.write_data       = 32'h0000_ff03;
    bus.write_enabled    = 1'b1;
    step();
    bus.eret_flush    = 1'b0;
    bus.write_enabled = 1'b0;
    rd(REG_STATUS, 3'd0, v);
    n_checks++; if (v !== 32'h0040_0000) $display("FAIL eret_over_wr got=%h exp=%h", v, 32'h0040_0000); else n_pass++;
  endtask

  task automatic test_cause_write();
    logic [31:0] v;
    mtc0(REG_CAUSE, 3'd0, 32'hffff_ffff);
    rd(REG_CAUSE, 3'd0, v);
    n_checks++; if (v !== 32'h0000_0300) $display("FAIL cause_mask got=%h exp=%h", v, 32'h0000_0300); else n_pass++;
    mtc0(REG_STATUS, 3'd0, 32'hffff_ffff);
    rd(REG_STATUS, 3'd0, v);
    n_checks++; if (v !== 32'h0040_ff03) $display("FAIL status_mask got=%h exp=%h", v, 32'h0040_ff03); else n_pass++;
    mtc0(REG_STATUS, 3'd0, 32'h0);
    mtc0(REG_CAUSE, 3'd0, 32'h0);
  endtask

  task automatic test_interrupts();
    logic [31:0] v;
    hardware_interrupt = 6'b000001;
    mtc0(REG_STATUS, 3'd0, 32'h0000_0401);
    rd(REG_CAUSE, 3'd0, v);
    n_checks++; if (v !== 32'h0000_0400) $display("FAIL hw_ip2 cause=%h exp=%h", v, 32'h0000_0400); else n_pass++;
    n_checks++; if (interrupt_pending !== 1'b1) $display("FAIL hw_irq got=%b exp=1", interrupt_pending); else n_pass++;
    hardware_interrupt = 6'b100000;
    step();
    rd(REG_CAUSE, 3'd0, v);
    n_checks++; if (v !== 32'h0000_8000) $display("FAIL hw_ip7 cause=%h exp=%h", v, 32'h0000_8000); else n_pass++;
    n_checks++; if (interrupt_pending !== 1'b0) $display("FAIL hw_masked got=%b exp=0", interrupt_pending); else n_pass++;
    hardware_interrupt = 6'b000000;
    mtc0(REG_STATUS, 3'd0, 32'h0000_0101);
    mtc0(REG_CAUSE, 3'd0, 32'h0000_0100);
    n_checks++; if (interrupt_pending !== 1'b1) $display("FAIL sw_irq got=%b exp=1", interrupt_pending); else n_pass++;
    mtc0(REG_STATUS, 3'd0, 32'h0000_0103);
    n_checks++; if (interrupt_pending !== 1'b0) $display("FAIL exl_masks got=%b exp=0", interrupt_pending); else n_pass++;
    mtc0(REG_STATUS, 3'd0, 32'h0000_0100);
    n_checks++; if (interrupt_pending !== 1'b0) $display("FAIL ie_masks got=%b exp=0", interrupt_pending); else n_pass++;
    mtc0(REG_STATUS, 3'd0, 32'h0);
    mtc0(REG_CAUSE, 3'd0, 32'h0);
  endtask

  task automatic test_unimplemented();
    logic [31:0] v;
    mtc0(5'd8, 3'd0, 32'hdead_beef);
    rd(5'd8, 3'd0, v);
    n_checks++; if (v !== 32'h0) $display("FAIL reg8_read got=%h exp=0", v); else n_pass++;
    mtc0(REG_STATUS, 3'd1, 32'h0000_ffff);
    rd(REG_STATUS, 3'd0, v);
    n_checks++; if (v !== 32'h0040_0000) $display("FAIL sel1_ignored got=%h exp=%h", v, 32'h0040_0000); else n_pass++;
    rd(REG_STATUS, 3'd1, v);
    n_checks++; if (v !== 32'h0) $display("FAIL sel1_read got=%h exp=0", v); else n_pass++;
    mtc0(REG_EPC, 3'd0, 32'h1234_5678);
    n_checks++; if (exception_program_count !== 32'h1234_5678) $display("FAIL epc_write got=%h exp=%h", exception_program_count, 32'h1234_5678); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_timer();
    test_exception();
    test_nested();
    test_priority();
    test_cause_write();
    test_interrupts();
    test_unimplemented();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
